// File: rtl/alu_op_pkg.sv
// rtl/alu_op_pkg.sv - ALU operation codes and shared execute-stage types
package alu_op_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOTHING = 3'b000;
  localparam logic [OP_W-1:0] OP_ADD     = 3'b001;
  localparam logic [OP_W-1:0] OP_SUB     = 3'b010;
  localparam logic [OP_W-1:0] OP_AND     = 3'b011;
  localparam logic [OP_W-1:0] OP_OR      = 3'b100;
  localparam logic [OP_W-1:0] OP_SLT     = 3'b101;
  localparam logic [OP_W-1:0] OP_RSV6    = 3'b110;
  localparam logic [OP_W-1:0] OP_RSV7    = 3'b111;

  // Occupancy of the two-entry output buffer (main + skid).
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_MAIN  = 2'b01,
    OCC_FULL  = 2'b10
  } occ_e;

  // Reserved encodings flag an illegal instruction downstream.
  function automatic logic op_is_reserved(input logic [OP_W-1:0] op);
    return (op == OP_RSV6) || (op == OP_RSV7);
  endfunction

endpackage

// File: rtl/ex_alu_stage_if.sv
// rtl/ex_alu_stage_if.sv - decode-side and EX/MEM-side handshake bundle of the ALU stage
interface ex_alu_stage_if
  import alu_op_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);

  // Input side (from decode / ALU controller)
  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAG_W-1:0] in_tag;

  // Output side (toward EX/MEM)
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_zero;
  logic             out_ovf;
  logic             out_illegal;

  // Pipeline around the stage: drives operands and downstream ready.
  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_zero, out_ovf, out_illegal
  );

  // The ALU stage itself.
  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_zero, out_ovf, out_illegal
  );

endinterface

// File: rtl/ex_alu_core.sv
// rtl/ex_alu_core.sv - combinational ALU: (op, a, b) -> (result, zero, ovf, illegal)
module ex_alu_core
  import alu_op_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             illegal
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] b_neg;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             less;

  // Subtraction is done as a + (~b + 1) so the overflow rule can look at the
  // sign of the negated operand actually added.
  assign b_neg = ~b + WIDTH'(1);
  assign sum   = a + b;
  assign diff  = a + b_neg;
  assign less  = $signed(a) < $signed(b);

  // Operation decode; reserved codes and NOTHING leave result at zero.
  always_comb begin
    result  = '0;
    ovf     = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_NOTHING: result = '0;
      OP_ADD: begin
        result = sum;
        ovf    = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        result = diff;
        ovf    = (a[MSB] == b_neg[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_SLT: result = {{(WIDTH-1){1'b0}}, less};
      default: begin
        result  = '0;
        illegal = op_is_reserved(op);
      end
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/ex_alu_stage.sv
// rtl/ex_alu_stage.sv - execute-stage ALU with registered main/skid output buffer
module ex_alu_stage
  import alu_op_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  ex_alu_stage_if.slave  bus
);

  occ_e state;
  occ_e state_nxt;

  logic             in_ready_q;
  logic             accept;
  logic             drain;
  logic             load_main_new;
  logic             load_main_skid;
  logic             load_skid;

  logic [WIDTH-1:0] c_result;
  logic             c_zero;
  logic             c_ovf;
  logic             c_illegal;

  logic [WIDTH-1:0] main_result;
  logic [TAG_W-1:0] main_tag;
  logic             main_zero;
  logic             main_ovf;
  logic             main_illegal;

  logic [WIDTH-1:0] skid_result;
  logic [TAG_W-1:0] skid_tag;
  logic             skid_zero;
  logic             skid_ovf;
  logic             skid_illegal;

  // The result is computed before the buffer so both entries hold finished results.
  ex_alu_core #(.WIDTH(WIDTH)) u_core (
    .op      (bus.in_op),
    .a       (bus.in_a),
    .b       (bus.in_b),
    .result  (c_result),
    .zero    (c_zero),
    .ovf     (c_ovf),
    .illegal (c_illegal)
  );

  assign accept = bus.in_valid && in_ready_q;
  assign drain  = (state != OCC_EMPTY) && bus.out_ready;

  // Occupancy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= OCC_EMPTY;
    else     state <= state_nxt;
  end

  // Next occupancy and buffer load selects; flush overrides accept and drain.
  always_comb begin
    state_nxt      = state;
    load_main_new  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = OCC_EMPTY;
    end else begin
      case (state)
        OCC_EMPTY: begin
          if (accept) begin
            load_main_new = 1'b1;
            state_nxt     = OCC_MAIN;
          end
        end
        OCC_MAIN: begin
          if (accept && drain) begin
            load_main_new = 1'b1;
          end else if (accept) begin
            load_skid = 1'b1;
            state_nxt = OCC_FULL;
          end else if (drain) begin
            state_nxt = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (drain) begin
            load_main_skid = 1'b1;
            state_nxt      = OCC_MAIN;
          end
        end
        default: state_nxt = OCC_EMPTY;
      endcase
    end
  end

  // in_ready is its own flop so downstream stalls never reach decode combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) in_ready_q <= 1'b1;
    else     in_ready_q <= (state_nxt != OCC_FULL);
  end

  // Main entry: loads a fresh result or the older skid entry, otherwise holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_result  <= '0;
      main_tag     <= '0;
      main_zero    <= 1'b0;
      main_ovf     <= 1'b0;
      main_illegal <= 1'b0;
    end else if (load_main_new) begin
      main_result  <= c_result;
      main_tag     <= bus.in_tag;
      main_zero    <= c_zero;
      main_ovf     <= c_ovf;
      main_illegal <= c_illegal;
    end else if (load_main_skid) begin
      main_result  <= skid_result;
      main_tag     <= skid_tag;
      main_zero    <= skid_zero;
      main_ovf     <= skid_ovf;
      main_illegal <= skid_illegal;
    end
  end

  // Skid entry: catches the accept that arrives while main is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_result  <= '0;
      skid_tag     <= '0;
      skid_zero    <= 1'b0;
      skid_ovf     <= 1'b0;
      skid_illegal <= 1'b0;
    end else if (load_skid) begin
      skid_result  <= c_result;
      skid_tag     <= bus.in_tag;
      skid_zero    <= c_zero;
      skid_ovf     <= c_ovf;
      skid_illegal <= c_illegal;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = (state != OCC_EMPTY);
  assign bus.out_result  = main_result;
  assign bus.out_tag     = main_tag;
  assign bus.out_zero    = main_zero;
  assign bus.out_ovf     = main_ovf;
  assign bus.out_illegal = main_illegal;

endmodule
